// File: rtl/fir_folded.sv
// Folded FIR filter: one shared multiply-accumulate unit walks all ORDER+1 taps per sample,
// with run-time loadable coefficients, round-half-up scaling and output saturation.
module fir_folded #(
    parameter int DATA_WIDTH = 13,
    parameter int COEF_WIDTH = 13,
    parameter int ORDER      = 8,
    parameter int FRAC_BITS  = 12
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             VIN,
    output logic                             RDY,
    input  logic signed [DATA_WIDTH-1:0]     DIN,
    input  logic                             COEF_WE,
    input  logic [$clog2(ORDER+1)-1:0]       COEF_ADDR,
    input  logic signed [COEF_WIDTH-1:0]     COEF_DIN,
    output logic signed [DATA_WIDTH-1:0]     DOUT,
    output logic                             VOUT
);
    localparam int ADDR_W = $clog2(ORDER + 1);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + ADDR_W;
    localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(ORDER);
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0] tap_q  [ORDER+1];
    logic signed [DATA_WIDTH-1:0] tap_d  [ORDER+1];
    logic signed [COEF_WIDTH-1:0] coef_q [ORDER+1];
    logic signed [COEF_WIDTH-1:0] coef_d [ORDER+1];
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [ADDR_W-1:0]            k_q, k_d;
    logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                         vout_q, vout_d;
    logic                         rdy_q, rdy_d;
    logic signed [PROD_W-1:0]     prod;
    logic                         accept;

    // Result is one bit wider than the accumulator so the half-LSB add cannot wrap.
    function automatic logic signed [ACC_W:0] rnd(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] x;
        x = {a[ACC_W-1], a};
        if (FRAC_BITS > 0) x = x + ((ACC_W+1)'(1) <<< RND_SH);
        return x >>> FRAC_BITS;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_W:0] x);
        if (x > SAT_MAX) return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        if (x < SAT_MIN) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        return x[DATA_WIDTH-1:0];
    endfunction

    assign accept = (state_q == IDLE) && rdy_q && VIN;
    assign prod   = coef_q[k_q] * tap_q[k_q];

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        coef_d  = coef_q;
        acc_d   = acc_q;
        k_d     = k_q;
        dout_d  = dout_q;
        vout_d  = 1'b0;
        rdy_d   = rdy_q;

        if ((state_q == IDLE) && COEF_WE && (COEF_ADDR <= LAST_TAP))
            coef_d[COEF_ADDR] = COEF_DIN;

        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                if (accept) begin
                    tap_d[0] = DIN;
                    for (int i = 1; i <= ORDER; i++) tap_d[i] = tap_q[i-1];
                    acc_d   = '0;
                    k_d     = '0;
                    rdy_d   = 1'b0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                if (k_q == LAST_TAP) state_d = OUT;
                else                 k_d = k_q + 1'b1;
            end
            OUT: begin
                dout_d  = sat(rnd(acc_q));
                vout_d  = 1'b1;
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            for (int i = 0; i <= ORDER; i++) begin
                tap_q[i]  <= '0;
                coef_q[i] <= '0;
            end
            acc_q  <= '0;
            k_q    <= '0;
            dout_q <= '0;
            vout_q <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            coef_q  <= coef_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
            rdy_q   <= rdy_d;
        end
    end

    assign RDY  = rdy_q;
    assign DOUT = dout_q;
    assign VOUT = vout_q;
endmodule

// File: tb/tb_fir_folded.sv
// Directed bench for fir_folded: a default instance and a FRAC_BITS=0 instance share one stimulus.
module tb_fir_folded;
    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               VIN = 1'b0;
    logic signed [12:0] DIN = '0;
    logic               COEF_WE = 1'b0;
    logic [3:0]         COEF_ADDR = '0;
    logic signed [12:0] COEF_DIN = '0;
    logic               rdy_a, rdy_b, vout_a, vout_b;
    logic signed [12:0] dout_a, dout_b;

    int checks   = 0;
    int failures = 0;

    fir_folded u_def (
        .CLK(CLK), .RST(RST), .VIN(VIN), .RDY(rdy_a), .DIN(DIN),
        .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DIN(COEF_DIN),
        .DOUT(dout_a), .VOUT(vout_a)
    );

    fir_folded #(.FRAC_BITS(0)) u_f0 (
        .CLK(CLK), .RST(RST), .VIN(VIN), .RDY(rdy_b), .DIN(DIN),
        .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DIN(COEF_DIN),
        .DOUT(dout_b), .VOUT(vout_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int din;
        int exp;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #4 RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int addr, input int val);
        COEF_WE   = 1'b1;
        COEF_ADDR = 4'(addr);
        COEF_DIN  = 13'(val);
        @(posedge CLK);
        #1 COEF_WE = 1'b0;
    endtask

    task automatic wait_rdy();
        int g = 0;
        while (!rdy_a && g < 40) begin
            @(posedge CLK);
            #1 g++;
        end
        chk("rdy_wait", int'(rdy_a), 1);
    endtask

    task automatic wait_vout(output int cyc);
        cyc = 0;
        do begin
            @(posedge CLK);
            #1 cyc++;
        end while (!vout_a && cyc < 30);
    endtask

    task automatic send(input int din, output int d_def, output int d_f0);
        int cyc;
        wait_rdy();
        VIN = 1'b1;
        DIN = 13'(din);
        @(posedge CLK);
        #1 VIN = 1'b0;
        wait_vout(cyc);
        chk("latency", cyc, 10);
        d_def = dout_a;
        d_f0  = dout_b;
    endtask

    initial begin
        vec_t tbl[7];
        int   da, db, cyc, last, nacc, nvout;
        int   q[$];

        tbl[0] = '{100, 50};
        tbl[1] = '{3, 2};
        tbl[2] = '{-3, -1};
        tbl[3] = '{1, 1};
        tbl[4] = '{-1, 0};
        tbl[5] = '{4095, 2048};
        tbl[6] = '{-4096, -2048};

        // Reset state
        #2;
        chk("rst_rdy", int'(rdy_a), 0);
        chk("rst_vout", int'(vout_a), 0);
        chk("rst_dout", int'(dout_a), 0);
        @(posedge CLK);
        @(posedge CLK);
        #4 RST = 1'b0;
        @(posedge CLK);
        #1 chk("rdy_after_rst", int'(rdy_a), 1);

        // Scaling and rounding: coef[0] = 0.5
        wr(0, 2048);
        foreach (tbl[i]) begin
            send(tbl[i].din, da, db);
            chk($sformatf("scale_din_%0d", tbl[i].din), da, tbl[i].exp);
        end

        // Impulse response on the integer instance
        do_reset();
        for (int i = 0; i <= 8; i++) wr(i, i + 1);
        for (int j = 0; j < 11; j++) begin
            send((j == 0) ? 1 : 0, da, db);
            chk($sformatf("impulse_%0d", j), db, (j < 9) ? j + 1 : 0);
        end

        // Saturation
        do_reset();
        for (int i = 0; i <= 8; i++) wr(i, 4095);
        for (int j = 0; j < 9; j++) send(4095, da, db);
        chk("sat_pos_def", da, 4095);
        chk("sat_pos_f0", db, 4095);
        for (int j = 0; j < 9; j++) send(-4096, da, db);
        chk("sat_neg_def", da, -4096);
        chk("sat_neg_f0", db, -4096);

        // Handshake under continuous VIN: f0 output equals the accepted sample
        do_reset();
        wr(0, 1);
        last = -1;
        nacc = 0;
        nvout = 0;
        for (int i = 0; i < 80; i++) begin
            if (vout_b) begin
                nvout++;
                if (q.size() == 0) chk("hs_unexpected_vout", 1, 0);
                else chk("hs_dout", int'(dout_b), q.pop_front());
            end
            DIN = 13'(i);
            VIN = (i < 66);
            if (rdy_a && VIN) begin
                q.push_back(i);
                nacc++;
                if (last >= 0) chk("hs_rdy_spacing", i - last, 11);
                last = i;
            end
            @(posedge CLK);
            #1;
        end
        VIN = 1'b0;
        chk("hs_vout_per_accept", nvout, nacc);

        // Coefficient write during MAC is dropped
        do_reset();
        wr(0, 1);
        wait_rdy();
        VIN = 1'b1;
        DIN = 13'sd5;
        @(posedge CLK);
        #1 VIN = 1'b0;
        wr(0, 7);
        wait_vout(cyc);
        chk("mac_write_dropped", int'(dout_b), 5);
        send(6, da, db);
        chk("mac_write_coef_kept", db, 6);

        // Out-of-range address is dropped (taps now 0,6,5)
        wr(9, 100);
        send(0, da, db);
        chk("addr9_dropped", db, 0);

        // Write on the accept edge applies to that sample (taps 3,0,6,5)
        wait_rdy();
        VIN       = 1'b1;
        DIN       = 13'sd3;
        COEF_WE   = 1'b1;
        COEF_ADDR = 4'd0;
        COEF_DIN  = 13'sd4;
        @(posedge CLK);
        #1;
        VIN     = 1'b0;
        COEF_WE = 1'b0;
        wait_vout(cyc);
        chk("write_on_accept", int'(dout_b), 12);

        // Reset in the fourth MAC cycle
        wait_rdy();
        VIN = 1'b1;
        DIN = 13'sd7;
        @(posedge CLK);
        #1 VIN = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("abort_dout", int'(dout_b), 0);
        chk("abort_vout", int'(vout_b), 0);
        chk("abort_rdy", int'(rdy_b), 0);
        @(posedge CLK);
        #4 RST = 1'b0;
        @(posedge CLK);
        #1 chk("abort_rdy_release", int'(rdy_a), 1);
        nvout = 0;
        for (int i = 0; i < 15; i++) begin
            if (vout_a || vout_b) nvout++;
            @(posedge CLK);
            #1;
        end
        chk("abort_no_vout", nvout, 0);
        for (int i = 1; i <= 8; i++) wr(i, 1);
        send(100, da, db);
        chk("abort_cleared_def", da, 0);
        chk("abort_cleared_f0", db, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fir_folded.md
Name: fir_folded

Overview:
- Parametrised successor of the direct-form 9-tap FIR: order, data width, coefficient width and fixed-point scaling are generic.
- Coefficients are held in an internal register file loaded at run time, replacing hard-wired coefficient ports.
- A single time-multiplexed multiply-accumulate unit processes one input sample per ORDER+3 cycles.
- Input handshake (valid/ready), round-half-up output scaling and saturation.
- Sits between the sample source and the DSP accelerator output stage.

Parameters:
- DATA_WIDTH, 13: signed width of input samples and output.
- COEF_WIDTH, 13: signed coefficient width.
- ORDER, 8: filter order; number of taps is ORDER+1.
- FRAC_BITS, 12: fractional bits of coefficients, removed from the result. Range 0..COEF_WIDTH-1.

Ports:
- CLK, in, 1: clock, rising edge.
- RST, in, 1: asynchronous, active-high reset.
- VIN, in, 1: input sample valid.
- RDY, out, 1: block ready to accept a sample.
- DIN, in, DATA_WIDTH: signed input sample.
- COEF_WE, in, 1: coefficient write enable.
- COEF_ADDR, in, clog2(ORDER+1): coefficient index.
- COEF_DIN, in, COEF_WIDTH: signed coefficient value.
- DOUT, out, DATA_WIDTH: signed filtered sample, registered.
- VOUT, out, 1: one-cycle pulse, DOUT valid.

Behaviour:

Reset (RST high, asynchronous):
- State goes to IDLE.
- Delay line taps 0..ORDER and all coefficients are cleared to 0.
- Accumulator and tap counter are cleared to 0.
- DOUT=0, VOUT=0, RDY=0 while RST is asserted; RDY=1 on the first edge after release.
- Reset asserted mid-MAC aborts the computation. No VOUT is produced for the aborted sample.

State machine IDLE -> MAC -> OUT -> IDLE:
- IDLE:
  - RDY=1.
  - A sample is accepted on an edge where VIN&&RDY.
  - On accept: tap[0]<=DIN, tap[i]<=tap[i-1] for i=1..ORDER, accumulator cleared, tap counter<=0, go to MAC.
- MAC:
  - RDY=0.
  - Each cycle: acc += coef[k]*tap[k], k increments.
  - Takes exactly ORDER+1 cycles (k=0..ORDER), then go to OUT.
  - VIN is ignored and DIN is not sampled.
- OUT:
  - RDY=0.
  - DOUT<=sat(round(acc)), VOUT<=1 for exactly one cycle, go to IDLE.

Latency and throughput:
- Sample accepted at edge n gives VOUT=1 in the cycle after edge n+ORDER+2.
- The earliest next accept is edge n+ORDER+3.
- With the defaults this is 11 cycles per sample.

Hold rule:
- DOUT holds its last value until the next OUT state.

Arithmetic:
- Product width is DATA_WIDTH+COEF_WIDTH.
- Accumulator width is DATA_WIDTH+COEF_WIDTH+clog2(ORDER+1); it must not overflow internally.
- Rounding is round half toward +inf: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift. When FRAC_BITS=0 there is no add.
- Saturation: r > 2^(DATA_WIDTH-1)-1 gives the maximum positive value; r < -2^(DATA_WIDTH-1) gives the minimum negative value.

Coefficient writes:
- A write takes effect only in IDLE: coef[COEF_ADDR]<=COEF_DIN.
- COEF_WE outside IDLE is dropped.
- COEF_ADDR > ORDER is dropped.
- A write and a sample accept on the same IDLE edge both take effect. The sample being accepted uses the new coefficient.

Test Plan:
- Scaling and round: default params, coef[0]=2048, others 0.
  - DIN=100 gives DOUT=50.
  - DIN=3 gives DOUT=2.
  - DIN=-3 gives DOUT=-1.
  - Each VOUT pulse comes exactly 10 cycles after its accept edge.
- Impulse response: FRAC_BITS=0, coef[i]=i+1. Feed DIN=1 then ten samples of 0.
  - Required DOUT sequence: 1,2,3,4,5,6,7,8,9,0,0.
- Saturation: defaults, all coefs 4095.
  - Nine samples of DIN=4095 give final DOUT=4095.
  - Nine samples of DIN=-4096 give final DOUT=-4096.
- Handshake: hold VIN=1 continuously with DIN incrementing every cycle.
  - RDY is high only one cycle in 11.
  - Only DIN values present on RDY-high edges enter the delay line.
  - Exactly one VOUT per accept.
- Coefficient write rules:
  - A write while in MAC leaves the coefficient unchanged; the next output reflects the old value.
  - A write with COEF_ADDR=9 (ORDER=8) has no effect.
  - A write on the same edge as an accept is used by that sample.
- Reset mid-operation: assert RST during the 4th MAC cycle.
  - DOUT=0, VOUT=0 and RDY=0 immediately, without waiting for a clock edge.
  - After release, RDY=1, delay line and coefficients are zero, and the next sample produces DOUT=0.
